alu_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single combinational ALU between two requesters, e.g. the execute stage and a future multi-cycle helper unit.
- Each requester issues operands and a control code over a valid/ready request channel, and receives the result and zero flag over a valid/ready response channel.
- The block registers the operands, drives the ALU for one cycle, captures its outputs and holds the response until it is accepted.

---
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands are registered toward the ALU, its outputs captured, and the response held until accepted.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    input  logic [CTRL_WIDTH-1:0] req0_ctrl,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    input  logic [CTRL_WIDTH-1:0] req1_ctrl,

    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,

    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [CTRL_WIDTH-1:0] alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,

    output logic                  busy
);

    // state | meaning
    // IDLE  | arbitrating; the winning requester sees ready
    // EXEC  | operands on the ALU for one cycle; result captured at its end
    // RESP  | response presented to the granted requester until taken
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   prio;
    logic   grant;
    logic   winner;
    logic   accept;
    logic   rsp_take;

    // With a single valid requester it wins outright; prio only breaks ties.
    always_comb begin
        winner = req1_valid;
        if (req0_valid && req1_valid) begin
            winner = prio;
        end
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b0;
        if (!rst) begin
            req0_ready = (state == IDLE) && req0_valid && !winner;
            req1_ready = (state == IDLE) && req1_valid &&  winner;
            rsp0_valid = (state == RESP) && !grant;
            rsp1_valid = (state == RESP) &&  grant;
            busy       = (state != IDLE);
        end
    end

    assign accept   = req0_ready || req1_ready;
    assign rsp_take = grant ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            grant      <= 1'b0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_ctrl   <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_op1  <= winner ? req1_op1  : req0_op1;
                alu_op2  <= winner ? req1_op2  : req0_op2;
                alu_ctrl <= winner ? req1_ctrl : req0_ctrl;
                grant    <= winner;
                prio     <= ~winner;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU attached to the ALU port.
// Directed scenarios plus a randomized run checked against a cycle-timing reference model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [31:0] alu_op1, alu_op2, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    logic        busy;

    int vec = 0;
    int miscmp = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    // Behavioural ALU: unknown codes pass op1 through; zero flag reports op1 == op2.
    function automatic logic [31:0] alu_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_res(alu_op1, alu_op2, alu_ctrl);
    assign alu_zero   = (alu_op1 == alu_op2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op1 = 32'h1; req0_op2 = 32'h2; req0_ctrl = 4'h3;
        req1_op1 = 32'h4; req1_op2 = 32'h5; req1_ctrl = 4'h6;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick();
        tick();
        #1;
        vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin miscmp++; $display("FAIL reset_req_ready: got %b%b want 00", req0_ready, req1_ready); end
        vec++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin miscmp++; $display("FAIL reset_rsp_valid: got %b%b want 00", rsp0_valid, rsp1_valid); end
        vec++; if (alu_op1 !== 32'h0 || alu_op2 !== 32'h0 || alu_ctrl !== 4'h0) begin miscmp++; $display("FAIL reset_alu: got %h %h %h want 0 0 0", alu_op1, alu_op2, alu_ctrl); end
        vec++; if (rsp_result !== 32'h0 || rsp_zero !== 1'b0) begin miscmp++; $display("FAIL reset_rsp: got %h %b want 0 0", rsp_result, rsp_zero); end
        do_reset();
    endtask

    task automatic test_single_add();
        do_reset();
        req0_valid = 1'b1; req0_op1 = 32'd5; req0_op2 = 32'd7; req0_ctrl = 4'd0;
        #1;
        vec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscmp++; $display("FAIL add_accept: got %b%b want 10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        vec++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7 || alu_ctrl !== 4'd0) begin miscmp++; $display("FAIL add_alu_ops: got %0d %0d %0d want 5 7 0", alu_op1, alu_op2, alu_ctrl); end
        vec++; if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin miscmp++; $display("FAIL add_exec: got busy=%b rsp0_valid=%b want 1 0", busy, rsp0_valid); end
        tick();
        #1;
        vec++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin miscmp++; $display("FAIL add_rsp_valid: got %b%b want 10", rsp0_valid, rsp1_valid); end
        vec++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin miscmp++; $display("FAIL add_result: got %0d %b want 12 0", rsp_result, rsp_zero); end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        #1;
        vec++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin miscmp++; $display("FAIL add_done: got busy=%b rsp0_valid=%b want 0 0", busy, rsp0_valid); end
    endtask

    task automatic test_both_valid();
        do_reset();
        req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd3; req0_ctrl = 4'd1;
        req1_valid = 1'b1; req1_op1 = 32'd4;  req1_op2 = 32'd4; req1_ctrl = 4'd0;
        #1;
        vec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscmp++; $display("FAIL both_first: got %b%b want 10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        vec++; if (req1_ready !== 1'b0) begin miscmp++; $display("FAIL both_exec_ready: got %b want 0", req1_ready); end
        tick();
        #1;
        vec++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd7 || rsp_zero !== 1'b0) begin miscmp++; $display("FAIL both_rsp0: got v=%b %0d z=%b want 1 7 0", rsp0_valid, rsp_result, rsp_zero); end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        #1;
        vec++; if (req1_ready !== 1'b1) begin miscmp++; $display("FAIL both_second: got %b want 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        tick();
        #1;
        vec++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin miscmp++; $display("FAIL both_rsp1_valid: got %b%b want 01", rsp0_valid, rsp1_valid); end
        vec++; if (rsp_result !== 32'd8 || rsp_zero !== 1'b1) begin miscmp++; $display("FAIL both_rsp1: got %0d %b want 8 1", rsp_result, rsp_zero); end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1'b1; req0_op1 = 32'd9; req0_op2 = 32'd2; req0_ctrl = 4'd1;
        req1_valid = 1'b1; req1_op1 = 32'd1; req1_op2 = 32'd1; req1_ctrl = 4'd0;
        #1;
        vec++; if (req0_ready !== 1'b1) begin miscmp++; $display("FAIL bp_accept: got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        tick();
        rsp1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            vec++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd7) begin miscmp++; $display("FAIL bp_hold[%0d]: got v=%b %0d want 1 7", i, rsp0_valid, rsp_result); end
            vec++; if (req1_ready !== 1'b0 || busy !== 1'b1) begin miscmp++; $display("FAIL bp_block[%0d]: got ready=%b busy=%b want 0 1", i, req1_ready, busy); end
            tick();
        end
        rsp1_ready = 1'b0;
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        #1;
        vec++; if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin miscmp++; $display("FAIL bp_release: got v=%b ready1=%b want 0 1", rsp0_valid, req1_ready); end
        req1_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_contention();
        logic [31:0] o1[2], o2[2];
        logic [3:0]  oc[2];
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        last_w;
        int          grants, last_cyc;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            o1[i] = $urandom; o2[i] = $urandom; oc[i] = 4'($urandom_range(4, 0));
        end
        grants = 0; last_cyc = 0; last_w = 1'b0; exp_res = '0; exp_zero = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
            req0_valid = 1'b1; req0_op1 = o1[0]; req0_op2 = o2[0]; req0_ctrl = oc[0];
            req1_valid = 1'b1; req1_op1 = o1[1]; req1_op2 = o2[1]; req1_ctrl = oc[1];
            #1;
            if (rsp0_valid || rsp1_valid) begin
                vec++; if (rsp1_valid !== last_w || rsp_result !== exp_res || rsp_zero !== exp_zero) begin miscmp++; $display("FAIL cont_rsp: got ch=%b %h %b want %b %h %b", rsp1_valid, rsp_result, rsp_zero, last_w, exp_res, exp_zero); end
            end
            if (req0_ready || req1_ready) begin
                vec++; if (req1_ready !== grants[0] || (req0_ready && req1_ready)) begin miscmp++; $display("FAIL cont_order[%0d]: got %b%b want grant %0d", grants, req0_ready, req1_ready, grants % 2); end
                if (grants > 0) begin
                    vec++; if (cyc - last_cyc !== 3) begin miscmp++; $display("FAIL cont_period[%0d]: got %0d cycles want 3", grants, cyc - last_cyc); end
                end
                last_w = req1_ready;
                exp_res = alu_res(o1[last_w], o2[last_w], oc[last_w]);
                exp_zero = (o1[last_w] == o2[last_w]);
                o1[last_w] = $urandom; o2[last_w] = $urandom; oc[last_w] = 4'($urandom_range(4, 0));
                last_cyc = cyc;
                grants++;
            end
            tick();
        end
        vec++; if (grants !== 6) begin miscmp++; $display("FAIL cont_count: got %0d grants want 6", grants); end
        do_reset();
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        req0_valid = 1'b1; req0_op1 = 32'd3; req0_op2 = 32'd3; req0_ctrl = 4'd0;
        #1;
        vec++; if (req0_ready !== 1'b1) begin miscmp++; $display("FAIL rx_accept: got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        rsp0_ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vec++; if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin miscmp++; $display("FAIL rx_idle: got busy=%b v=%b%b want 0 00", busy, rsp0_valid, rsp1_valid); end
        vec++; if (alu_op1 !== 32'h0 || alu_op2 !== 32'h0 || alu_ctrl !== 4'h0) begin miscmp++; $display("FAIL rx_alu: got %h %h %h want 0 0 0", alu_op1, alu_op2, alu_ctrl); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            vec++; if (rsp0_valid !== 1'b0) begin miscmp++; $display("FAIL rx_no_rsp[%0d]: got %b want 0", i, rsp0_valid); end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        vec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscmp++; $display("FAIL rx_prio: got %b%b want 10", req0_ready, req1_ready); end
        rsp0_ready = 1'b0;
        do_reset();
    endtask

    task automatic test_invalid_ctrl();
        logic [31:0] b;
        do_reset();
        b = $urandom;
        req1_valid = 1'b1; req1_op1 = 32'hDEADBEEF; req1_op2 = b; req1_ctrl = 4'd15;
        #1;
        vec++; if (req1_ready !== 1'b1) begin miscmp++; $display("FAIL inv_accept: got %b want 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        #1;
        vec++; if (alu_ctrl !== 4'd15 || alu_op1 !== 32'hDEADBEEF || alu_op2 !== b) begin miscmp++; $display("FAIL inv_alu: got %h %h %h want f deadbeef %h", alu_ctrl, alu_op1, alu_op2, b); end
        tick();
        #1;
        vec++; if (rsp1_valid !== 1'b1 || rsp_result !== 32'hDEADBEEF) begin miscmp++; $display("FAIL inv_rsp: got v=%b %h want 1 deadbeef", rsp1_valid, rsp_result); end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
    endtask

    // Reference model tracks phase by cycles since accept, per the request/response timing rules.
    task automatic test_random();
        logic        pend[2];
        logic [31:0] p1[2], p2[2];
        logic [3:0]  pc[2];
        logic        rr[2];
        int          ph;
        logic        m_prio, m_g, w;
        logic        er0, er1;
        logic [31:0] m_res;
        logic        m_zero;
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        p1[0] = '0; p1[1] = '0; p2[0] = '0; p2[1] = '0; pc[0] = '0; pc[1] = '0;
        ph = 0; m_prio = 1'b0; m_g = 1'b0; m_res = '0; m_zero = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(2, 0) == 0) begin
                    pend[i] = 1'b1;
                    p1[i] = $urandom;
                    p2[i] = ($urandom_range(3, 0) == 0) ? p1[i] : $urandom;
                    pc[i] = 4'($urandom_range(15, 0));
                end
                rr[i] = ($urandom_range(2, 0) != 0);
            end
            req0_valid = pend[0]; req0_op1 = p1[0]; req0_op2 = p2[0]; req0_ctrl = pc[0];
            req1_valid = pend[1]; req1_op1 = p1[1]; req1_op2 = p2[1]; req1_ctrl = pc[1];
            rsp0_ready = rr[0]; rsp1_ready = rr[1];
            #1;
            er0 = (ph == 0) && pend[0] && (!pend[1] || !m_prio);
            er1 = (ph == 0) && pend[1] && (!pend[0] ||  m_prio);
            vec++; if (req0_ready !== er0 || req1_ready !== er1) begin miscmp++; $display("FAIL rnd_ready@%0d: got %b%b want %b%b", cyc, req0_ready, req1_ready, er0, er1); end
            vec++; if (rsp0_valid !== (ph == 2 && !m_g) || rsp1_valid !== (ph == 2 && m_g)) begin miscmp++; $display("FAIL rnd_rsp_valid@%0d: got %b%b phase %0d grant %b", cyc, rsp0_valid, rsp1_valid, ph, m_g); end
            vec++; if (busy !== (ph != 0)) begin miscmp++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, ph != 0); end
            if (ph == 2) begin
                vec++; if (rsp_result !== m_res || rsp_zero !== m_zero) begin miscmp++; $display("FAIL rnd_result@%0d: got %h %b want %h %b", cyc, rsp_result, rsp_zero, m_res, m_zero); end
            end
            if (er0 || er1) begin
                w = er1;
                m_res = alu_res(p1[w], p2[w], pc[w]);
                m_zero = (p1[w] == p2[w]);
                m_g = w;
                m_prio = ~w;
                pend[w] = 1'b0;
                ph = 1;
            end else if (ph == 1) begin
                ph = 2;
            end else if (ph == 2 && rr[m_g]) begin
                ph = 0;
            end
            tick();
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_both_valid();
        test_backpressure();
        test_contention();
        test_reset_mid_exec();
        test_invalid_ctrl();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
